// File: rtl/netlist_seq_pkg.sv
// Shared types and constants for the netlist pattern sequencer.
// The MISR tap mask selects bits 15, 13, 12 and 10 as feedback.
package netlist_seq_pkg;

   localparam int SIG_W = 16;

   localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/netlist_seq_sig.sv
// Signature accumulator for the pattern sequencer.
// With SEQ_MISR_EN defined it is a 16-bit MISR; otherwise it counts captured ones.
module netlist_seq_sig
   import netlist_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
`ifdef SEQ_MISR_EN
         sig_d = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)} ^ {{(SIG_W-1){1'b0}}, bit_in};
`else
         sig_d = sig_q + {{(SIG_W-1){1'b0}}, bit_in};
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/netlist_pattern_sequencer.sv
// Sweeps every input pattern of a small combinational cluster and compresses its output.
// Signature mode is selected by SEQ_MISR_EN inside netlist_seq_sig.
module netlist_pattern_sequencer
   import netlist_seq_pkg::*;
#(
   parameter int               N_IN   = 5,
   parameter int               SETTLE = 2,
   parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output state_e           dbg_state
);

   localparam int              CNT_W     = N_IN + 1;
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'((1 << N_IN) - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       settle_q, settle_d;
   logic             ok_q, ok_d;
   logic             sig_clr, sig_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         settle_q <= '0;
         ok_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         ok_q     <= ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = APPLY;
         APPLY:   if (abort) state_d = DONE;
                  else if (settle_q == 4'd1) state_d = CAPTURE;
         CAPTURE: if (abort || cnt_q == LAST_PAT) state_d = DONE;
                  else state_d = APPLY;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Abort suppresses the capture so an interrupted sweep never reports the last sample.
   always_comb begin
      cnt_d    = cnt_q;
      settle_d = settle_q;
      ok_d     = ok_q;
      sig_clr  = 1'b0;
      sig_en   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            cnt_d    = '0;
            settle_d = SETTLE_LD;
            ok_d     = 1'b0;
            sig_clr  = 1'b1;
         end
         APPLY: if (!abort) settle_d = settle_q - 4'd1;
         CAPTURE: if (!abort) begin
            sig_en   = 1'b1;
            settle_d = SETTLE_LD;
            if (cnt_q == LAST_PAT) ok_d = 1'b1;
            else                   cnt_d = cnt_q + CNT_ONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy      = (state_q == APPLY) || (state_q == CAPTURE);
      done      = (state_q == DONE);
      pass      = ok_q && (signature == GOLDEN);
      dbg_state = state_q;
   end

   assign dut_in = cnt_q[N_IN-1:0];

   netlist_seq_sig u_sig (
      .clk    (clk),
      .rst    (rst),
      .clr    (sig_clr),
      .en     (sig_en),
      .bit_in (dut_out),
      .sig    (signature)
   );

endmodule

// File: tb/tb_netlist_pattern_sequencer.sv
// Directed bench for netlist_pattern_sequencer with a behavioural cluster model.
// Expected signatures come from an independent accumulation model (count or MISR).
module tb_netlist_pattern_sequencer;
  import netlist_seq_pkg::*;

  localparam int N_IN = 5;
  localparam logic [15:0] GOLDEN = 16'h0010;
  localparam int M_ONE = 0, M_XOR = 1, M_ZERO = 2;

  logic clk, rst, start, abort, dut_out;
  logic [N_IN-1:0] dut_in;
  logic busy, done, pass;
  logic [15:0] signature;
  state_e dbg_state;

  int mode;
  int cyc;
  int n_vec, n_err;
  logic [31:0] exp_q[$];

  netlist_pattern_sequencer #(.N_IN(N_IN), .SETTLE(2), .GOLDEN(GOLDEN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cluster(input int m, input logic [N_IN-1:0] p);
    case (m)
      M_ONE:   return 1'b1;
      M_XOR:   return p[0] ^ p[1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb dut_out = cluster(mode, dut_in);

  function automatic logic [15:0] model_sig(input int m, input int npat);
    logic [15:0] s;
    logic b;
    logic [N_IN-1:0] p;
    s = '0;
    for (int i = 0; i < npat; i++) begin
      p = N_IN'(i);
      b = cluster(m, p);
`ifdef SEQ_MISR_EN
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {15'b0, b};
`else
      s = s + {15'b0, b};
`endif
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  int at;
  logic [15:0] s_exp;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    mode = M_ONE; rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_dut_in", 32'(dut_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_sig", 32'(signature), 0);

    // full sweep, constant-one cluster
    for (int i = 0; i < 96; i++) exp_q.push_back(32'(i / 3));
    pulse_start();
    check("s1_busy", 32'(busy), 1);
    while (cyc <= 96) begin
      check("s1_dut_in", 32'(dut_in), exp_q.pop_front());
      if (done) check("s1_early_done", 32'(done), 0);
      step();
    end
    s_exp = model_sig(M_ONE, 32);
    check("s1_done97", 32'(done), 1);
    check("s1_busy97", 32'(busy), 0);
    check("s1_sig", 32'(signature), 32'(s_exp));
    check("s1_pass", 32'(pass), 32'(s_exp == GOLDEN));
    step();
    check("s1_done_pulse", 32'(done), 0);
    check("s1_sig_held", 32'(signature), 32'(s_exp));
    check("s1_idle", 32'(dbg_state), 32'(IDLE));

    // xor cluster matching GOLDEN
    mode = M_XOR;
    pulse_start();
    wait_done(150, at);
    s_exp = model_sig(M_XOR, 32);
    check("s2_done_cycle", 32'(at), 97);
    check("s2_sig", 32'(signature), 32'(s_exp));
    check("s2_pass", 32'(pass), 32'(s_exp == GOLDEN));
    step();
    check("s2_busy_after", 32'(busy), 0);
    check("s2_pass_held", 32'(pass), 32'(s_exp == GOLDEN));

    // abort at cycle 10
    mode = M_ONE;
    pulse_start();
    check("s3_pass_clr", 32'(pass), 0);
    while (cyc < 10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s3_done", 32'(done), 1);
    check("s3_pass", 32'(pass), 0);
    check("s3_sig", 32'(signature), 32'(model_sig(M_ONE, 3)));
    check("s3_dut_in", 32'(dut_in), 3);
    step();
    check("s3_sig_frozen", 32'(signature), 32'(model_sig(M_ONE, 3)));
    check("s3_dut_in_frozen", 32'(dut_in), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s3_idle_abort_state", 32'(dbg_state), 32'(IDLE));
    check("s3_idle_abort_done", 32'(done), 0);

    // abort on the final capture discards the sample
    pulse_start();
    while (cyc < 96) step();
    check("s4_final_capture", 32'(dbg_state), 32'(CAPTURE));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s4_done", 32'(done), 1);
    check("s4_sig", 32'(signature), 32'(model_sig(M_ONE, 31)));
    check("s4_pass", 32'(pass), 0);
    step();

    // reset mid-sweep beats a coincident start
    pulse_start();
    while (cyc < 40) step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("s5_state", 32'(dbg_state), 32'(IDLE));
    check("s5_dut_in", 32'(dut_in), 0);
    check("s5_sig", 32'(signature), 0);
    check("s5_busy", 32'(busy), 0);
    step(); step();
    check("s5_still_idle", 32'(dbg_state), 32'(IDLE));

    // zero cluster, starts while busy and in DONE are ignored
    mode = M_ZERO;
    pulse_start();
    while (cyc < 97) begin
      start = (cyc == 5 || cyc == 50);
      step();
    end
    start = 1'b0;
    check("s6_done97", 32'(done), 1);
    check("s6_sig", 32'(signature), 0);
    check("s6_pass", 32'(pass), 32'(GOLDEN == 16'h0000));
    start = 1'b1;
    step();
    start = 1'b0;
    check("s6_done_start_ign", 32'(dbg_state), 32'(IDLE));
    check("s6_busy", 32'(busy), 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("s6_start_abort", 32'(dbg_state), 32'(APPLY));
    check("s6_start_abort_in", 32'(dut_in), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s6_abort_apply", 32'(done), 1);
    step();
    check("s6_back_idle", 32'(dbg_state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/netlist_pattern_sequencer.md
NETLIST_PATTERN_SEQUENCER -- requirements
Module: netlist_pattern_sequencer

Interface
REQ-001 Parameter N_IN, default 5: number of inputs on the combinational cell cluster under control, range 1..8.
REQ-002 Parameter SETTLE, default 2: number of cycles each pattern is held before capture, range 1..15.
REQ-003 Parameter GOLDEN, default 16'h0000: expected final signature.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: pulse that begins a sweep; ignored unless the block is idle.
REQ-007 Port abort, input, 1: terminates the sweep in progress.
REQ-008 Port dut_in, output, N_IN: pattern driven onto the cluster inputs (n_0 = bit 0).
REQ-009 Port dut_out, input, 1: cluster output (n_8-style single output).
REQ-010 Port busy, output, 1: high while a sweep is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when a sweep completes or is aborted.
REQ-012 Port pass, output, 1: signature equals GOLDEN; valid from done until the next start.
REQ-013 Port signature, output, 16: accumulated signature; held after done.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, APPLY, CAPTURE and DONE.
REQ-015 In IDLE, start=1 SHALL clear the pattern counter and signature, load the settle counter with SETTLE, clear pass, and enter APPLY.
REQ-016 dut_in SHALL equal the pattern counter in every state and SHALL be registered, with no combinational path from any input.
REQ-017 APPLY SHALL last exactly SETTLE cycles, then enter CAPTURE.
REQ-018 CAPTURE SHALL last one cycle, sample dut_out and update the signature.
REQ-019 From CAPTURE: if the counter equals 2^N_IN-1, enter DONE; otherwise increment the counter, reload the settle counter and enter APPLY.
REQ-020 DONE SHALL last one cycle with done=1, then enter IDLE; pass SHALL be registered on DONE entry.
REQ-021 A full sweep SHALL take 2^N_IN*(SETTLE+1) cycles from the cycle after start is sampled, with done high on the following cycle (cycle 97 for the default parameters).
REQ-022 busy SHALL be 1 in APPLY and CAPTURE only.
REQ-023 abort in APPLY or CAPTURE SHALL enter DONE on the next cycle with pass forced to 0 and the signature frozen; abort in IDLE or DONE has no effect.
REQ-024 If abort and the final CAPTURE coincide, abort SHALL win: the sample is discarded and pass=0.
REQ-025 start while busy or in DONE SHALL be ignored; start and abort high together in IDLE SHALL start a sweep.
REQ-026 The pattern counter SHALL be N_IN+1 bits wide internally and SHALL never wrap during a sweep.

Reset
REQ-027 On rst=1 the block SHALL enter IDLE with dut_in=0, busy=0, done=0, pass=0 and signature=0, overriding all other inputs, including mid-sweep.

Configuration
REQ-028 The macro SEQ_MISR_EN SHALL select the signature mode.
- Defined: signature is a 16-bit MISR, sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {15'b0, dut_out}.
- Undefined: signature is a saturating-free count of captured ones, zero-extended to 16 bits.

Structure
REQ-029 Package netlist_seq_pkg SHALL hold the state enum, SIG_W=16 and the MISR tap mask.
REQ-030 Signature accumulation SHALL be a sub-module, netlist_seq_sig, with clk, rst, clr, en, bit_in and sig ports; the SEQ_MISR_EN selection SHALL be confined to it.

Verification (defaults unless stated; SEQ_MISR_EN undefined unless stated)
REQ-031 Cluster model with dut_out=1 constant, start pulse -> dut_in steps 0..31 holding each value 3 cycles, done at cycle 97, signature=32, pass=0.
REQ-032 Cluster model dut_out=dut_in[0]^dut_in[1], GOLDEN=16 -> signature=16, pass=1, busy low after done.
REQ-033 abort asserted at cycle 10 -> done at cycle 11, pass=0, signature=count of ones captured so far (at most 3), dut_in frozen at 3.
REQ-034 rst asserted at cycle 40 -> next cycle IDLE, dut_in=0, signature=0, and a start pulse at cycle 40 is ignored.
REQ-035 SEQ_MISR_EN defined, dut_out=0 constant -> signature=16'h0000 at done; start pulses during busy cause no restart.
